// File: rtl/m72_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | m72_irq_ctrl : vblank/raster interrupt controller with vector cycle    |
// | Optional raster source: define M72_RASTER_IRQ_EN       Rev 1.0         |
// +-----------------------------------------------------------------------+
module m72_irq_ctrl #(
  parameter logic [8:0] VBL_LINE = 9'd256,
  parameter logic [8:0] RASTER_H = 9'd0,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [8:0]  h_count,
  input  logic [8:0]  v_count,
  input  logic        io_cs,
  input  logic        io_we,
  input  logic [1:0]  io_addr,
  input  logic [15:0] io_din,
  input  logic [1:0]  io_sel,
  output logic [15:0] io_dout,
  output logic        io_ack,
  output logic        int_rq,
  input  logic        int_ack,
  input  logic        vec_stb,
  output logic [15:0] vec_dout,
  output logic        vec_ack
);

  localparam logic [7:0] c_vec_vbl  = VEC_BASE;
  localparam logic [7:0] c_vec_ras  = VEC_BASE + 8'd2;
  localparam logic [7:0] c_vec_spur = VEC_BASE + 8'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VEC  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_vec;
  logic        r_clr_vbl, r_clr_ras;
  logic        w_vec_clr_vbl, w_vec_clr_ras;

  logic        r_vbl_en, r_vbl_pend, r_vbl_hit_d;
  logic        w_vbl_hit, w_vbl_set, w_vbl_clr;
  logic [8:0]  w_cmp;
  logic        w_ras_en, w_ras_pend;
  logic        w_vbl_req, w_ras_req;

  logic        r_io_ack, r_int_rq;
  logic [15:0] r_io_dout, w_rd_data;
  logic        w_wr, w_wr_lo, w_wr_hi;
  logic        w_unused;

  // A write commits only on the first cycle of a strobe so a held strobe
  // cannot repeat a write-1-to-clear against a freshly set pending bit.
  assign w_wr    = io_cs & io_we & ~r_io_ack;
  assign w_wr_lo = w_wr & io_sel[0];
  assign w_wr_hi = w_wr & io_sel[1];

  assign w_vbl_hit = (v_count == VBL_LINE) && (h_count == 9'd0);
  assign w_vbl_set = w_vbl_hit & ~r_vbl_hit_d;
  assign w_vbl_clr = (w_wr_lo && (io_addr == 2'd2) && io_din[0]) || w_vec_clr_vbl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vbl_hit_d <= 1'b0;
      r_vbl_pend  <= 1'b0;
      r_vbl_en    <= 1'b0;
    end else begin
      r_vbl_hit_d <= w_vbl_hit;
      if (w_vbl_set)
        r_vbl_pend <= 1'b1;
      else if (w_vbl_clr)
        r_vbl_pend <= 1'b0;
      if (w_wr_lo && (io_addr == 2'd1))
        r_vbl_en <= io_din[0];
    end
  end

`ifdef M72_RASTER_IRQ_EN
  logic [8:0] r_cmp;
  logic       r_ras_en, r_ras_pend, r_ras_hit_d;
  logic       w_ras_hit, w_ras_set, w_ras_clr;

  assign w_ras_hit = (v_count == r_cmp) && (h_count == RASTER_H);
  assign w_ras_set = w_ras_hit & ~r_ras_hit_d;
  assign w_ras_clr = (w_wr_lo && (io_addr == 2'd2) && io_din[1]) || w_vec_clr_ras;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmp       <= 9'd0;
      r_ras_en    <= 1'b0;
      r_ras_pend  <= 1'b0;
      r_ras_hit_d <= 1'b0;
    end else begin
      r_ras_hit_d <= w_ras_hit;
      if (w_ras_set)
        r_ras_pend <= 1'b1;
      else if (w_ras_clr)
        r_ras_pend <= 1'b0;
      if (w_wr_lo && (io_addr == 2'd1))
        r_ras_en <= io_din[1];
      if (w_wr_lo && (io_addr == 2'd0))
        r_cmp[7:0] <= io_din[7:0];
      if (w_wr_hi && (io_addr == 2'd0))
        r_cmp[8] <= io_din[8];
    end
  end

  assign w_cmp      = r_cmp;
  assign w_ras_en   = r_ras_en;
  assign w_ras_pend = r_ras_pend;
  assign w_unused   = ^io_din[15:9];
`else
  assign w_cmp      = 9'd0;
  assign w_ras_en   = 1'b0;
  assign w_ras_pend = 1'b0;
  assign w_unused   = ^{io_din[15:1], io_sel[1], w_vec_clr_ras, RASTER_H};
`endif

  assign w_vbl_req = r_vbl_pend & r_vbl_en;
  assign w_ras_req = w_ras_pend & w_ras_en;

  always_comb begin
    w_rd_data = 16'h0000;
    case (io_addr)
      2'd0:    w_rd_data = {7'd0, w_cmp};
      2'd1:    w_rd_data = {14'd0, w_ras_en, r_vbl_en};
      2'd2:    w_rd_data = {14'd0, w_ras_pend, r_vbl_pend};
      default: w_rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_io_ack  <= 1'b0;
      r_io_dout <= 16'h0000;
      r_int_rq  <= 1'b0;
    end else begin
      r_io_ack  <= io_cs;
      r_io_dout <= io_cs ? w_rd_data : 16'h0000;
      r_int_rq  <= w_vbl_req | w_ras_req;
    end
  end

  assign io_ack  = r_io_ack;
  assign io_dout = r_io_dout;
  assign int_rq  = r_int_rq;

  // Winner is latched on entry to VEC; spurious cycles latch no clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_vec     <= 8'h00;
      r_clr_vbl <= 1'b0;
      r_clr_ras <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && int_ack && vec_stb) begin
        if (w_vbl_req) begin
          r_vec     <= c_vec_vbl;
          r_clr_vbl <= 1'b1;
          r_clr_ras <= 1'b0;
        end else if (w_ras_req) begin
          r_vec     <= c_vec_ras;
          r_clr_vbl <= 1'b0;
          r_clr_ras <= 1'b1;
        end else begin
          r_vec     <= c_vec_spur;
          r_clr_vbl <= 1'b0;
          r_clr_ras <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    vec_ack       = 1'b0;
    vec_dout      = 16'h0000;
    w_vec_clr_vbl = 1'b0;
    w_vec_clr_ras = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (int_ack && vec_stb)
          w_state_nxt = S_VEC;
      end
      S_VEC: begin
        vec_ack       = 1'b1;
        vec_dout      = {8'h00, r_vec};
        w_vec_clr_vbl = r_clr_vbl;
        w_vec_clr_ras = r_clr_ras;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (!vec_stb)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_m72_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_m72_irq_ctrl : randomized bench with a register/event-level model   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_m72_irq_ctrl;

`ifdef M72_RASTER_IRQ_EN
  localparam bit RASTER_ON = 1'b1;
`else
  localparam bit RASTER_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [8:0]  h_count, v_count;
  logic        io_cs, io_we;
  logic [1:0]  io_addr;
  logic [15:0] io_din;
  logic [1:0]  io_sel;
  logic [15:0] io_dout;
  logic        io_ack;
  logic        int_rq;
  logic        int_ack, vec_stb;
  logic [15:0] vec_dout;
  logic        vec_ack;

  m72_irq_ctrl dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .h_count  (h_count),
    .v_count  (v_count),
    .io_cs    (io_cs),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_sel   (io_sel),
    .io_dout  (io_dout),
    .io_ack   (io_ack),
    .int_rq   (int_rq),
    .int_ack  (int_ack),
    .vec_stb  (vec_stb),
    .vec_dout (vec_dout),
    .vec_ack  (vec_ack)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: register contents and pending flags as the software sees them.
  logic [8:0] m_cmp;
  logic       m_ve, m_re, m_vp, m_rp;
  logic       m_prev_vh, m_prev_rh;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cmp = 9'd0; m_ve = 1'b0; m_re = 1'b0; m_vp = 1'b0; m_rp = 1'b0;
    m_prev_vh = 1'b0; m_prev_rh = 1'b0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
    case (a)
      2'd0: if (RASTER_ON) begin
        if (s[0]) m_cmp[7:0] = d[7:0];
        if (s[1]) m_cmp[8]   = d[8];
      end
      2'd1: if (s[0]) begin
        m_ve = d[0];
        m_re = RASTER_ON ? d[1] : 1'b0;
      end
      2'd2: if (s[0]) begin
        if (d[0]) m_vp = 1'b0;
        if (d[1]) m_rp = 1'b0;
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {7'd0, m_cmp};
      2'd1:    return {14'd0, m_re, m_ve};
      2'd2:    return {14'd0, m_rp, m_vp};
      default: return 16'h0000;
    endcase
  endfunction

  // One clock: scan events are judged from the counters now presented;
  // a same-cycle write-1-to-clear is applied before the set so the set wins.
  task automatic tick(input bit do_wr);
    bit vh, rh, ve_evt, re_evt;
    vh = (v_count == 9'd256) && (h_count == 9'd0);
    rh = RASTER_ON && (v_count == m_cmp) && (h_count == 9'd0);
    ve_evt = vh && !m_prev_vh;
    re_evt = rh && !m_prev_rh;
    m_prev_vh = vh;
    m_prev_rh = rh;
    if (do_wr) model_write(io_addr, io_din, io_sel);
    if (ve_evt) m_vp = 1'b1;
    if (re_evt) m_rp = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic park();
    v_count = 9'd511;
    h_count = 9'd5;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
    io_cs = 1'b1; io_we = 1'b1; io_addr = a; io_din = d; io_sel = s;
    tick(1'b1);
    chk("wr_ack", {15'd0, io_ack}, 16'd1);
    io_cs = 1'b0; io_we = 1'b0;
    tick(1'b0);
  endtask

  task automatic bus_read(input logic [1:0] a);
    io_cs = 1'b1; io_we = 1'b0; io_addr = a; io_din = 16'h0000; io_sel = 2'b11;
    tick(1'b0);
    chk("rd_ack", {15'd0, io_ack}, 16'd1);
    chk("rd_data", io_dout, model_read(a));
    tick(1'b0);
    chk("rd_ack_hold", {15'd0, io_ack}, 16'd1);
    io_cs = 1'b0;
    tick(1'b0);
    chk("rd_ack_drop", {15'd0, io_ack}, 16'd0);
  endtask

  task automatic check_irq(input string tag);
    tick(1'b0);
    tick(1'b0);
    chk(tag, {15'd0, int_rq}, {15'd0, (m_vp & m_ve) | (m_rp & m_re)});
  endtask

  task automatic do_inta(input string tag);
    logic [15:0] exp;
    bit cv, cr;
    cv = 1'b0; cr = 1'b0;
    if (m_vp && m_ve) begin exp = 16'h0020; cv = 1'b1; end
    else if (m_rp && m_re) begin exp = 16'h0022; cr = 1'b1; end
    else exp = 16'h0024;
    int_ack = 1'b1; vec_stb = 1'b1;
    tick(1'b0);
    chk({tag, "_vack"}, {15'd0, vec_ack}, 16'd1);
    chk({tag, "_vec"}, vec_dout, exp);
    tick(1'b0);
    chk({tag, "_vack_once"}, {15'd0, vec_ack}, 16'd0);
    chk({tag, "_vec_idle"}, vec_dout, 16'h0000);
    if (cv) m_vp = 1'b0;
    if (cr) m_rp = 1'b0;
    int_ack = 1'b0; vec_stb = 1'b0;
    tick(1'b0);
  endtask

  task automatic scan_pulse(input logic [8:0] line, input int hold);
    v_count = line; h_count = 9'd0;
    for (int i = 0; i < hold; i++) tick(1'b0);
    park();
    tick(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    io_cs = 1'b0; io_we = 1'b0; io_addr = 2'd0; io_din = 16'h0; io_sel = 2'b00;
    int_ack = 1'b0; vec_stb = 1'b0;
    park();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_io_ack", {15'd0, io_ack}, 16'd0);
    chk("rst_io_dout", io_dout, 16'h0000);
    chk("rst_int_rq", {15'd0, int_rq}, 16'd0);
    chk("rst_vec_ack", {15'd0, vec_ack}, 16'd0);
    chk("rst_vec_dout", vec_dout, 16'h0000);
    reset_n = 1'b1;
    tick(1'b0);
    bus_read(2'd1);

    // vblank: registered int_rq one cycle after the pending bit
    bus_write(2'd1, 16'h0001, 2'b01);
    v_count = 9'd256; h_count = 9'd0;
    tick(1'b0);
    chk("vbl_rq_early", {15'd0, int_rq}, 16'd0);
    tick(1'b0);
    chk("vbl_rq", {15'd0, int_rq}, {15'd0, m_vp & m_ve});
    park();
    tick(1'b0);
    do_inta("vbl_inta");
    check_irq("vbl_rq_after");

    // raster at line 100, then a long hold must not retrigger
    bus_write(2'd0, 16'd100, 2'b11);
    bus_write(2'd1, 16'h0003, 2'b01);
    bus_read(2'd0);
    bus_read(2'd1);
    v_count = 9'd100; h_count = 9'd0;
    tick(1'b0);
    check_irq("ras_rq");
    do_inta("ras_inta");
    repeat (512) tick(1'b0);
    chk("ras_hold_rq", {15'd0, int_rq}, 16'd0);
    park();
    tick(1'b0);
    bus_read(2'd2);

    // both pending: vblank first, then raster
    bus_write(2'd0, 16'd50, 2'b01);
    scan_pulse(9'd50, 1);
    scan_pulse(9'd256, 2);
    bus_read(2'd2);
    do_inta("both1");
    do_inta("both2");
    check_irq("both_rq");

    // same-cycle W1C and new vblank event: set wins
    scan_pulse(9'd256, 1);
    v_count = 9'd256; h_count = 9'd0;
    bus_write(2'd2, 16'h0001, 2'b01);
    park();
    tick(1'b0);
    bus_read(2'd2);

    // disable keeps pending, re-enable re-raises int_rq
    bus_write(2'd1, 16'h0000, 2'b01);
    check_irq("dis_rq");
    bus_read(2'd2);
    bus_write(2'd1, 16'h0001, 2'b01);
    check_irq("reen_rq");
    do_inta("reen_inta");

    // spurious acknowledge: nothing cleared
    bus_write(2'd1, 16'h0000, 2'b01);
    scan_pulse(9'd256, 1);
    do_inta("spur");
    bus_read(2'd2);

    // byte-lane gating on cmp bit 8 and ctrl
    bus_write(2'd0, 16'h01FF, 2'b10);
    bus_read(2'd0);
    bus_write(2'd1, 16'h0003, 2'b10);
    bus_read(2'd1);
    bus_write(2'd3, 16'hFFFF, 2'b11);
    bus_read(2'd3);

    // reset while in VEC abandons the cycle
    bus_write(2'd1, 16'h0001, 2'b01);
    check_irq("pre_rst_rq");
    io_cs = 1'b1; io_we = 1'b0; io_addr = 2'd1; io_sel = 2'b11;
    int_ack = 1'b1; vec_stb = 1'b1;
    tick(1'b0);
    chk("pre_rst_vack", {15'd0, vec_ack}, 16'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_vack", {15'd0, vec_ack}, 16'd0);
    chk("mid_rst_vec", vec_dout, 16'h0000);
    chk("mid_rst_int_rq", {15'd0, int_rq}, 16'd0);
    chk("mid_rst_io_ack", {15'd0, io_ack}, 16'd0);
    chk("mid_rst_io_dout", io_dout, 16'h0000);
    io_cs = 1'b0; int_ack = 1'b0; vec_stb = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("post_rst_vack", {15'd0, vec_ack}, 16'd0);
    end
    bus_read(2'd2);
    bus_read(2'd1);

    // randomized mix of scan events, register traffic and acknowledges
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: scan_pulse(9'd256, $urandom_range(1, 3));
        1: begin
          logic [8:0] ln;
          case ($urandom_range(0, 3))
            0, 1:    ln = m_cmp;
            2:       ln = 9'd256;
            default: ln = 9'($urandom_range(0, 510));
          endcase
          scan_pulse(ln, $urandom_range(1, 3));
        end
        2: bus_write(2'($urandom_range(0, 3)), 16'($urandom), 2'($urandom_range(0, 3)));
        3: bus_read(2'($urandom_range(0, 3)));
        4: do_inta("rnd_inta");
        default: check_irq("rnd_rq");
      endcase
    end
    check_irq("final_rq");
    bus_read(2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
